// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - ALU front-end op sequencer; optional macro ALU_SEQ_DIV0_TRAP_EN
module alu_op_sequencer #(
  parameter int DATA_W     = 32,
  parameter int MULDIV_LAT = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [4:0]          req_opcode,
  input  logic [DATA_W-1:0]   req_b,
  input  logic [DATA_W-1:0]   req_y,
  output logic [DATA_W-1:0]   alu_b,
  output logic [DATA_W-1:0]   alu_y,
  output logic [4:0]          alu_opcode,
  input  logic [2*DATA_W-1:0] alu_z,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_lo,
  output logic [DATA_W-1:0]   rsp_hi,
  output logic                rsp_hi_we,
  output logic                rsp_err,
  output logic                busy
);

  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_MAX = 5'b10010;
  localparam logic [3:0] MD_CNT = 4'(MULDIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic       op_err;

  logic accept;
  logic exec_done;
  logic req_is_muldiv;
  logic req_illegal;
  logic req_trap;
  logic req_fault;

  assign accept        = req_valid && (state == IDLE);
  assign exec_done     = (state == EXEC) && (cnt == 4'd0);
  assign req_is_muldiv = (req_opcode == OP_MUL) || (req_opcode == OP_DIV);
  assign req_illegal   = (req_opcode > OP_MAX);
`ifdef ALU_SEQ_DIV0_TRAP_EN
  assign req_trap      = (req_opcode == OP_DIV) && (req_y == '0);
`else
  assign req_trap      = 1'b0;
`endif
  // Faulted ops skip the ALU wait and return a zeroed error response.
  assign req_fault     = req_illegal || req_trap;

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nx = EXEC;
      end
      EXEC: begin
        if (cnt == 4'd0) state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, latency countdown and result capture.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      alu_b      <= '0;
      alu_y      <= '0;
      alu_opcode <= '0;
      cnt        <= '0;
      op_err     <= 1'b0;
      rsp_lo     <= '0;
      rsp_hi     <= '0;
      rsp_hi_we  <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        alu_b      <= req_b;
        alu_y      <= req_y;
        alu_opcode <= req_opcode;
        cnt        <= (req_is_muldiv && !req_fault) ? MD_CNT : 4'd0;
        op_err     <= req_fault;
      end else if ((state == EXEC) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (exec_done) begin
        if (op_err) begin
          rsp_lo    <= '0;
          rsp_hi    <= '0;
          rsp_hi_we <= 1'b0;
          rsp_err   <= 1'b1;
        end else begin
          rsp_lo    <= alu_z[DATA_W-1:0];
          rsp_hi    <= alu_z[2*DATA_W-1:DATA_W];
          rsp_hi_we <= (alu_opcode == OP_MUL) || (alu_opcode == OP_DIV);
          rsp_err   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed bench for alu_op_sequencer (MULDIV_LAT=4)
module tb_alu_op_sequencer;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10010;

  logic        clk;
  logic        clr;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_opcode;
  logic [31:0] req_b;
  logic [31:0] req_y;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic [4:0]  alu_opcode;
  logic [63:0] alu_z;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_lo;
  logic [31:0] rsp_hi;
  logic        rsp_hi_we;
  logic        rsp_err;
  logic        busy;

  int vectors;
  int miscompares;

  alu_op_sequencer #(.DATA_W(32), .MULDIV_LAT(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_b      (req_b),
    .req_y      (req_y),
    .alu_b      (alu_b),
    .alu_y      (alu_y),
    .alu_opcode (alu_opcode),
    .alu_z      (alu_z),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_lo     (rsp_lo),
    .rsp_hi     (rsp_hi),
    .rsp_hi_we  (rsp_hi_we),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, act as the ALU by presenting z, and check latency and response.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] b,
                        input logic [31:0] y, input logic [63:0] z, input int lat,
                        input logic [31:0] elo, input logic [31:0] ehi,
                        input logic ewe, input logic eerr);
    @(negedge clk);
    chk({tag, "_req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1; req_opcode = op; req_b = b; req_y = y; alu_z = z; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_alu_b"}, alu_b, b);
    chk({tag, "_alu_y"}, alu_y, y);
    chk({tag, "_alu_opcode"}, alu_opcode, op);
    for (int i = 0; i < lat; i++) begin
      chk({tag, "_no_early_rsp"}, rsp_valid, 0);
      chk({tag, "_busy"}, busy, 1);
      @(negedge clk);
    end
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_lo"}, rsp_lo, elo);
    chk({tag, "_rsp_hi"}, rsp_hi, ehi);
    chk({tag, "_rsp_hi_we"}, rsp_hi_we, ewe);
    chk({tag, "_rsp_err"}, rsp_err, eerr);
    chk({tag, "_req_ready_resp"}, req_ready, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_rsp_done"}, rsp_valid, 0);
    chk({tag, "_idle"}, busy, 0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    clr = 1'b1; req_valid = 1'b0; req_opcode = '0; req_b = '0; req_y = '0;
    alu_z = '0; rsp_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_rsp_lo", rsp_lo, 0);
    chk("rst_rsp_err", rsp_err, 0);
    clr = 1'b0;

    // 1. add: 1-cycle latency
    run_op("add", OP_ADD, 32'd123, 32'd7, 64'd130, 1, 32'd130, 32'd0, 1'b0, 1'b0);
    // 2. mul: MULDIV_LAT latency, HI/LO write
    run_op("mul", OP_MUL, 32'd12, 32'd4, 64'd48, 4, 32'd48, 32'd0, 1'b1, 1'b0);
    run_op("mul_hi", OP_MUL, 32'h8000_0000, 32'd4, 64'h2_0000_0000, 4, 32'd0, 32'd2, 1'b1, 1'b0);
    run_op("div", OP_DIV, 32'd12, 32'd5, {32'd2, 32'd2}, 4, 32'd2, 32'd2, 1'b1, 1'b0);

    // 3. sub with response back-pressure and a request during RESP
    @(negedge clk);
    req_valid = 1'b1; req_opcode = OP_SUB; req_b = 32'd15; req_y = 32'd4; alu_z = 64'd11;
    @(negedge clk);
    req_valid = 1'b0;
    chk("sub_alu_b", alu_b, 15);
    @(negedge clk);
    chk("sub_rsp_valid", rsp_valid, 1);
    chk("sub_rsp_lo", rsp_lo, 11);
    alu_z = 64'hBAD0_BAD0_BAD0_BAD0;
    req_valid = 1'b1; req_opcode = OP_ADD; req_b = 32'd1; req_y = 32'd2;
    repeat (3) begin
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_lo", rsp_lo, 11);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_alu_b", alu_b, 15);
      chk("hold_alu_opcode", alu_opcode, OP_SUB);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_rsp_valid", rsp_valid, 0);
    chk("release_req_ready", req_ready, 1);
    chk("release_not_accepted", alu_b, 15);
    rsp_ready = 1'b0; alu_z = 64'd3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("late_accept_alu_b", alu_b, 1);
    chk("late_accept_alu_y", alu_y, 2);
    chk("late_accept_busy", busy, 1);
    @(negedge clk);
    chk("late_rsp_valid", rsp_valid, 1);
    chk("late_rsp_lo", rsp_lo, 3);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("late_idle", busy, 0);
    rsp_ready = 1'b0;

    // 4. illegal opcodes and the highest legal opcode
    run_op("illegal_1f", 5'b11111, 32'd5, 32'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1, 32'd0, 32'd0, 1'b0, 1'b1);
    run_op("illegal_13", 5'b10011, 32'd5, 32'd6, 64'h1234_5678_9ABC_DEF0, 1, 32'd0, 32'd0, 1'b0, 1'b1);
    run_op("not_legal", OP_NOT, 32'd5, 32'd0, 64'hFFFF_FFFA, 1, 32'hFFFF_FFFA, 32'd0, 1'b0, 1'b0);

    // 5. divide by zero
`ifdef ALU_SEQ_DIV0_TRAP_EN
    run_op("div0", OP_DIV, 32'd12, 32'd0, 64'hDEAD_BEEF_0000_0001, 1, 32'd0, 32'd0, 1'b0, 1'b1);
`else
    run_op("div0", OP_DIV, 32'd12, 32'd0, 64'hDEAD_BEEF_0000_0001, 4, 32'h0000_0001, 32'hDEAD_BEEF, 1'b1, 1'b0);
`endif

    // 6. clr in the middle of a mul
    @(negedge clk);
    req_valid = 1'b1; req_opcode = OP_MUL; req_b = 32'd9; req_y = 32'd9; alu_z = 64'd81;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_busy_before", busy, 1);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("abort_req_ready", req_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_alu_b", alu_b, 0);
    chk("abort_alu_opcode", alu_opcode, 0);
    chk("abort_rsp_lo", rsp_lo, 0);
    chk("abort_rsp_hi_we", rsp_hi_we, 0);
    @(negedge clk);
    clr = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 0);
      chk("abort_stays_idle", busy, 0);
    end
    run_op("post_abort_add", OP_ADD, 32'd14, 32'd4, 64'd18, 1, 32'd18, 32'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
